serial_tx: RTL and testbench

Parallel-in, serial-out frame transmitter. It is the sending end of the team's single-wire serial link and sits between a byte-wide producer and the line output. It accepts one DATA_W word per handshake and shifts it out LSB-first, framed by one start bit (0) and one stop bit (1). Each bit is held on the line for a fixed number of clocks.

---
 rtl/serial_tx_pkg.sv | 28 ++
 rtl/serial_tx_if.sv | 24 ++
 rtl/serial_tx_bit_timer.sv | 41 ++++
 rtl/serial_tx.sv | 137 +++++++++++++
 tb/tb_serial_tx.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg -- shared definitions for the single-wire serial link.
// Holds the frame state encoding and the line-level constants. The matching
// receiver imports this package too, so both ends agree on framing.
// No ports (package).
package serial_tx_pkg;

    // Frame phases seen on the line.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if -- producer/transmitter handshake plus the line outputs.
// Signals:
//   din   [DATA_W] payload word, sampled on the accepting edge
//   load           producer request
//   ready          transmitter idle, a frame may be accepted
//   txd            serial line, idles high
//   busy           frame on the line
//   done           one-cycle end-of-frame pulse
// Modports: master = producer side, slave = transmitter side.
interface serial_tx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] din;
    logic              load;
    logic              ready;
    logic              txd;
    logic              busy;
    logic              done;

    modport master (output din, output load,
                    input  ready, input txd, input busy, input done);
    modport slave  (input  din, input  load,
                    output ready, output txd, output busy, output done);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// serial_tx_bit_timer -- modulo-CLKS_PER_BIT counter that marks bit boundaries.
// Ports:
//   clk   clock
//   clr   synchronous clear to count 0 (reset or start of a new frame)
//   en    count enable (high while a frame is on the line)
//   tick  high during the last clock of each bit period
module serial_tx_bit_timer
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int              CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             wrap_s;

    assign wrap_s = (cnt_r == LAST);
    assign tick   = en & wrap_s;

    // Count 0..CLKS_PER_BIT-1 while enabled, wrapping explicitly so the
    // counter never relies on arithmetic overflow.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (wrap_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/serial_tx.sv
// serial_tx -- parallel-in, serial-out frame transmitter.
// Sends one DATA_W word per accepted request, LSB first, framed by a start
// bit (0) and a stop bit (1); every bit is held CLKS_PER_BIT clocks.
// Ports:
//   clk  clock, all state on the rising edge
//   clr  synchronous active-high reset (wins over load)
//   bus  serial_tx_if slave: din/load in; ready/txd/busy/done out (registered)
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input logic         clk,
    input logic         clr,
    serial_tx_if.slave  bus
);
    localparam int               IDX_W    = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state_r, state_n;
    logic [DATA_W-1:0] shreg_r, shreg_n;
    logic [IDX_W-1:0]  idx_r, idx_n;
    logic              txd_r, txd_n;
    logic              ready_r, ready_n;
    logic              busy_r, busy_n;
    logic              done_r, done_n;
    logic              accept_s;
    logic              tick_s;
    logic              timer_en_s;
    logic              timer_clr_s;

    assign accept_s    = (state_r == ST_IDLE) & bus.load;
    assign timer_en_s  = (state_r != ST_IDLE);
    // Restarting the timer on acceptance aligns the start bit to the edge.
    assign timer_clr_s = clr | accept_s;

    serial_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .clr  (timer_clr_s),
        .en   (timer_en_s),
        .tick (tick_s)
    );

    // State register plus registered copies of every output.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
            shreg_r <= {DATA_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            txd_r   <= LINE_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            shreg_r <= shreg_n;
            idx_r   <= idx_n;
            txd_r   <= txd_n;
            ready_r <= ready_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
        end
    end

    // Next-state logic; outputs are decoded from the next state so that the
    // registered line changes exactly on bit boundaries.
    always_comb begin
        state_n = state_r;
        shreg_n = shreg_r;
        idx_n   = idx_r;
        done_n  = 1'b0;
        txd_n   = LINE_IDLE;
        ready_n = 1'b1;
        busy_n  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n = ST_START;
                    shreg_n = bus.din;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_n = ST_DATA;
                    idx_n   = {IDX_W{1'b0}};
                end else begin
                    state_n = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_n = ST_STOP;
                    end else begin
                        idx_n   = idx_r + IDX_W'(1);
                        shreg_n = shreg_r >> 1;
                    end
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = ST_STOP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        case (state_n)
            ST_IDLE:  txd_n = LINE_IDLE;
            ST_START: txd_n = START_BIT;
            ST_DATA:  txd_n = shreg_n[0];
            ST_STOP:  txd_n = STOP_BIT;
            default:  txd_n = LINE_IDLE;
        endcase

        ready_n = (state_n == ST_IDLE);
        busy_n  = (state_n != ST_IDLE);
    end

    assign bus.txd   = txd_r;
    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx -- self-checking bench for serial_tx.
// Two instances run side by side from shared clr/load/din: the default
// 8-bit / 4-clocks-per-bit build and a 4-bit / 1-clock-per-bit build.
// A frame-level model (a frame bit vector indexed by elapsed cycles / bit
// length) predicts txd, busy, ready and done for every cycle.
module tb_serial_tx;
    logic clk;
    logic clr;

    serial_tx_if #(.DATA_W(8)) bus8 ();
    serial_tx_if #(.DATA_W(4)) bus4 ();

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut8 (
        .clk (clk),
        .clr (clr),
        .bus (bus8.slave)
    );

    serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut4 (
        .clk (clk),
        .clr (clr),
        .bus (bus4.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state: cycles since acceptance (-1 when idle) and the frame bits
    // (bit 0 start, then payload LSB first, then stop).
    int          pos8 = -1;
    int          pos4 = -1;
    logic [15:0] frame8 = 16'hFFFF;
    logic [15:0] frame4 = 16'hFFFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Advance the frame model by one clock given the inputs seen at the edge.
    task automatic model_step(input int w, input int c, input logic c_clr,
                              input logic c_load, input logic [7:0] c_din,
                              inout int pos, inout logic [15:0] frame,
                              output logic e_txd, output logic e_busy,
                              output logic e_ready, output logic e_done);
        logic was_busy;
        was_busy = (pos >= 0);
        e_done   = 1'b0;
        if (c_clr) begin
            pos = -1;
        end else if (!was_busy && c_load) begin
            frame    = 16'hFFFF;
            frame[0] = 1'b0;
            for (int i = 0; i < w; i++) frame[i+1] = c_din[i];
            frame[w+1] = 1'b1;
            pos = 0;
        end else if (was_busy) begin
            pos++;
            if (pos == (w + 2) * c) begin
                pos    = -1;
                e_done = 1'b1;
            end
        end
        e_busy  = (pos >= 0);
        e_ready = !e_busy;
        e_txd   = e_busy ? frame[pos / c] : 1'b1;
    endtask

    // One clock: predict, let the edge happen, then compare just after it.
    task automatic tick();
        logic t8, b8, r8, d8, t4, b4, r4, d4;
        model_step(8, 4, clr, bus8.load, bus8.din, pos8, frame8, t8, b8, r8, d8);
        model_step(4, 1, clr, bus4.load, {4'b0000, bus4.din}, pos4, frame4, t4, b4, r4, d4);
        @(posedge clk);
        #1;
        cyc++;
        check("txd8",   bus8.txd,   t8);
        check("busy8",  bus8.busy,  b8);
        check("ready8", bus8.ready, r8);
        check("done8",  bus8.done,  d8);
        check("txd4",   bus4.txd,   t4);
        check("busy4",  bus4.busy,  b4);
        check("ready4", bus4.ready, r4);
        check("done4",  bus4.done,  d4);
    endtask

    task automatic drive(input logic l, input logic [7:0] d);
        bus8.load = l;
        bus4.load = l;
        bus8.din  = d;
        bus4.din  = d[3:0];
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset held with a pending request: nothing may start.
        clr = 1'b1;
        drive(1'b1, 8'hFF);
        run(3);
        clr = 1'b0;
        drive(1'b0, 8'h00);
        run(2);

        // Single frame 0xA5.
        drive(1'b1, 8'hA5);
        tick();
        drive(1'b0, 8'h00);
        run(45);

        // Back-to-back: 0x01, then 0x80 requested through the done cycle.
        drive(1'b1, 8'h01);
        tick();
        drive(1'b0, 8'h00);
        run(39);
        drive(1'b1, 8'h80);
        run(3);
        drive(1'b0, 8'h00);
        run(45);

        // Requests while busy are ignored.
        drive(1'b1, 8'h3C);
        tick();
        drive(1'b0, 8'h00);
        run(9);
        drive(1'b1, 8'hFF);
        tick();
        drive(1'b0, 8'h00);
        run(14);
        drive(1'b1, 8'hFF);
        tick();
        drive(1'b0, 8'h00);
        run(25);

        // Mid-frame reset, then a clean frame.
        drive(1'b1, 8'h55);
        tick();
        drive(1'b0, 8'h00);
        run(17);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run(5);
        drive(1'b1, 8'h0F);
        tick();
        drive(1'b0, 8'h00);
        run(45);

        // 0x9 on the 4-bit, one-clock-per-bit build.
        drive(1'b1, 8'h09);
        tick();
        drive(1'b0, 8'h00);
        run(45);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            clr = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 3) == 0), 8'($urandom));
            tick();
        end
        clr = 1'b0;
        drive(1'b0, 8'h00);
        run(45);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
